// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a show-ahead async FIFO into a registered valid/ready stream with a 2-entry skid buffer
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic [1:0]       level,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);
    logic [1:0]       cnt_q, cnt_d;
    logic [DSIZE-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             run_q;
    logic             fetch, pop;
    assign fetch     = run_q & ~rempty & (cnt_q != 2'd2);
    assign pop       = out_valid & out_ready;
    assign rinc      = fetch;
    assign out_valid = cnt_q != 2'd0;
    assign out_data  = data0_q;
    assign level     = cnt_q;
    assign xfer_cnt  = xfer_q;
    // buffer occupancy: data0 is the head, data1 the skid slot filled only when the head is stalled
    always_comb begin
        cnt_d   = cnt_q;
        data0_d = data0_q;
        data1_d = data1_q;
        case (cnt_q)
            2'd0: if (fetch) begin
                data0_d = rdata;
                cnt_d   = 2'd1;
            end
            2'd1: if (fetch && pop) begin
                data0_d = rdata;
            end else if (fetch) begin
                data1_d = rdata;
                cnt_d   = 2'd2;
            end else if (pop) begin
                cnt_d = 2'd0;
            end
            2'd2: if (pop) begin
                data0_d = data1_q;
                cnt_d   = 2'd1;
            end
            default: cnt_d = 2'd0;
        endcase
        xfer_d = clr_cnt ? '0 : pop ? xfer_q + CNT_W'(1) : xfer_q;
    end
    // state registers; run holds fetching off until the first edge after reset release
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            xfer_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            xfer_q  <= xfer_d;
            run_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-based reference model of FIFO plus output buffer, directed and random stimulus
module tb_fifo_rd_stream;
    logic       clk = 1'b0;
    logic       rrst_n, rempty, out_ready, clr_cnt;
    logic [7:0] rdata, out_data;
    logic       rinc, out_valid;
    logic [1:0] level;
    logic [3:0] xfer_cnt;

    fifo_rd_stream #(.DSIZE(8), .CNT_W(4)) dut (
        .rclk(clk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .clr_cnt(clr_cnt), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0, failures = 0, pops = 0, rinc_seen = 0;
    logic [7:0] fifo_m[$], buf_m[$], sent_m[$];
    logic [7:0] last_m = 8'h00, first_word = 8'h00;
    logic [3:0] xfer_m = 4'h0;
    logic       run_m = 1'b0, first_pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        rempty = fifo_m.size() == 0;
        rdata  = rempty ? 8'($urandom) : fifo_m[0];
    endtask

    task automatic push(input logic [7:0] v);
        fifo_m.push_back(v);
        sent_m.push_back(v);
    endtask

    task automatic tick();
        logic       f, p, c;
        logic [7:0] w;
        @(negedge clk);
        f = run_m && fifo_m.size() > 0 && buf_m.size() < 2;
        p = buf_m.size() > 0 && out_ready;
        c = clr_cnt;
        if (buf_m.size() > 0) last_m = buf_m[0];
        chk("rinc", 32'(rinc), 32'(f));
        chk("out_valid", 32'(out_valid), 32'(buf_m.size() > 0));
        chk("level", 32'(level), 32'(buf_m.size()));
        chk("out_data", 32'(out_data), 32'(last_m));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(xfer_m));
        if (rinc) rinc_seen++;
        @(posedge clk);
        #1;
        if (p) begin
            w = buf_m.pop_front();
            pops++;
            if (first_pending) begin
                first_word    = w;
                first_pending = 1'b0;
            end
            chk("order", 32'(w), 32'(sent_m.pop_front()));
            xfer_m++;
        end
        if (c) xfer_m = 4'h0;
        if (f) buf_m.push_back(fifo_m.pop_front());
        run_m = 1'b1;
        drive();
    endtask

    task automatic check_reset_outputs();
        chk("rst_rinc", 32'(rinc), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_xfer", 32'(xfer_cnt), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rrst_n = 1'b1;
        @(posedge clk);
        #1 run_m = 1'b1;
        drive();
    endtask

    initial begin
        int wr, p0;
        logic done;
        rrst_n = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        drive();
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        release_reset();
        // empty FIFO: nothing may move
        repeat (20) tick();
        // preloaded 1..8 with the sink always ready
        for (int i = 1; i <= 8; i++) push(8'(i));
        drive();
        repeat (12) tick();
        chk("xfer_after_8", 32'(xfer_cnt), 8);
        // stalled sink: exactly two fetches, then drain in order
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(i));
        drive();
        rinc_seen = 0;
        repeat (5) tick();
        chk("two_pulses", rinc_seen, 2);
        chk("stall_data", 32'(out_data), 1);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("drained_level", 32'(level), 0);
        // slow writer, toggling sink
        wr = 0; p0 = pops; done = 1'b0;
        for (int n = 0; n < 600 && !done; n++) begin
            if (wr < 64 && $urandom_range(0, 2) == 0) begin
                push(8'(wr));
                wr++;
            end
            drive();
            out_ready = ~out_ready;
            tick();
            done = wr == 64 && fifo_m.size() == 0 && buf_m.size() == 0;
        end
        chk("stream_done", 32'(done), 1);
        chk("stream_count", pops - p0, 64);
        // counter wrap with a 4-bit counter
        out_ready = 1'b0; clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        for (int i = 0; i < 20; i++) push(8'($urandom));
        drive();
        out_ready = 1'b1;
        repeat (25) tick();
        chk("xfer_wrap", 32'(xfer_cnt), 4);
        // clear wins over a simultaneous pop
        out_ready = 1'b0;
        push(8'h5A); drive();
        repeat (3) tick();
        out_ready = 1'b1; clr_cnt = 1'b1; p0 = pops;
        tick();
        clr_cnt = 1'b0; out_ready = 1'b0;
        chk("clr_pop_popped", pops - p0, 1);
        chk("clr_pop_xfer", 32'(xfer_cnt), 0);
        // asynchronous reset with a full buffer
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        drive();
        repeat (4) tick();
        chk("full_before_rst", 32'(level), 2);
        #2 rrst_n = 1'b0;
        #1 check_reset_outputs();
        fifo_m.delete(); buf_m.delete(); sent_m.delete();
        run_m = 1'b0; xfer_m = 4'h0; last_m = 8'h00;
        drive();
        release_reset();
        for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
        drive();
        out_ready = 1'b1; first_pending = 1'b1;
        repeat (8) tick();
        chk("first_after_rst", 32'(first_pending), 0);
        chk("first_word", 32'(first_word), 32'h A0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
